// File: rtl/vec_pkg.sv
// Shared types and instruction field layout for the vector issue controller.
package vec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAZARD = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  localparam int REG_W   = 5;
  localparam int ALU_W   = 4;
  localparam int NREGS   = 1 << REG_W;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;
  localparam int ALU_LSB = 0;

endpackage

// File: rtl/vec_issue_ctrl_if.sv
// Fetch, ALU issue and writeback signals of the vector issue controller.
interface vec_issue_ctrl_if #(
  parameter int MAXVL = 16,
  parameter int LANES = 4,
  parameter int VLW   = $clog2(MAXVL + 1)
);
  import vec_pkg::*;

  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst;
  logic [VLW-1:0]   vl;
  logic             issue_valid;
  logic             issue_ready;
  logic [REG_W-1:0] issue_rs1;
  logic [REG_W-1:0] issue_rs2;
  logic [REG_W-1:0] issue_rd;
  logic [ALU_W-1:0] issue_alu_ctrl;
  logic [VLW-1:0]   issue_elem_base;
  logic [LANES-1:0] issue_lane_mask;
  logic             issue_last;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic             busy;

  modport slave (
    input  inst_valid, inst, vl, issue_ready, wb_valid, wb_rd,
    output inst_ready, issue_valid, issue_rs1, issue_rs2, issue_rd, issue_alu_ctrl,
           issue_elem_base, issue_lane_mask, issue_last, busy
  );

  modport master (
    output inst_valid, inst, vl, issue_ready, wb_valid, wb_rd,
    input  inst_ready, issue_valid, issue_rs1, issue_rs2, issue_rd, issue_alu_ctrl,
           issue_elem_base, issue_lane_mask, issue_last, busy
  );

endinterface

// File: rtl/vec_scoreboard.sv
// Per-register pending-write bits; register 0 can never be marked busy.
module vec_scoreboard
  import vec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] rd_idx_a,
  input  logic [REG_W-1:0] rd_idx_b,
  input  logic [REG_W-1:0] rd_idx_c,
  output logic             rd_busy_a,
  output logic             rd_busy_b,
  output logic             rd_busy_c,
  output logic             any_busy
);

  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  assign set_vec = set_en ? (NREGS'(1) << set_idx) : '0;
  assign clr_vec = clr_en ? (NREGS'(1) << clr_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_q <= '0;
    else      sb_q <= ((sb_q & ~clr_vec) | set_vec) & ~NREGS'(1);
  end

  assign rd_busy_a = sb_q[rd_idx_a];
  assign rd_busy_b = sb_q[rd_idx_b];
  assign rd_busy_c = sb_q[rd_idx_c];
  assign any_busy  = |sb_q;

endmodule

// File: rtl/vec_issue_ctrl.sv
// Accepts one instruction, waits out register hazards, then issues it as lane-parallel beats.
// state  | meaning
// IDLE   | ready for a new instruction
// HAZARD | holding instruction until rs1/rs2/rd are not pending
// ISSUE  | presenting beats to the ALU
module vec_issue_ctrl
  import vec_pkg::*;
#(
  parameter int MAXVL = 16,
  parameter int LANES = 4
) (
  input logic              clk,
  input logic              rst,
  vec_issue_ctrl_if.slave  bus
);

  localparam int VLW = $clog2(MAXVL + 1);

  state_t           state_q, state_d;
  logic [REG_W-1:0] rs1_q, rs2_q, rd_q;
  logic [ALU_W-1:0] alu_q;
  logic [VLW-1:0]   vl_q, base_q, vl_eff;
  logic [VLW:0]     base_next;
  logic             accept, hazard, beat_fire, last_beat, sb_set, sb_any;
  logic             haz_rs1, haz_rs2, haz_rd;
  logic             inst_ready, issue_valid;
  logic [LANES-1:0] lane_mask;

  assign vl_eff    = (bus.vl > VLW'(MAXVL)) ? VLW'(MAXVL) : bus.vl;
  assign accept    = (state_q == IDLE) && bus.inst_valid;
  assign hazard    = haz_rs1 | haz_rs2 | haz_rd;
  assign sb_set    = (state_q == HAZARD) && !hazard;
  assign beat_fire = (state_q == ISSUE) && bus.issue_ready;
  // Extra bit keeps the end-of-vector compare exact when base reaches MAXVL.
  assign base_next = {1'b0, base_q} + (VLW+1)'(LANES);
  assign last_beat = base_next >= {1'b0, vl_q};

  vec_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (sb_set),
    .set_idx   (rd_q),
    .clr_en    (bus.wb_valid),
    .clr_idx   (bus.wb_rd),
    .rd_idx_a  (rs1_q),
    .rd_idx_b  (rs2_q),
    .rd_idx_c  (rd_q),
    .rd_busy_a (haz_rs1),
    .rd_busy_b (haz_rs2),
    .rd_busy_c (haz_rd),
    .any_busy  (sb_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    inst_ready  = 1'b0;
    issue_valid = 1'b0;
    case (state_q)
      IDLE: begin
        inst_ready = 1'b1;
        if (accept && (vl_eff != '0)) state_d = HAZARD;
      end
      HAZARD: begin
        if (!hazard) state_d = ISSUE;
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (beat_fire && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      alu_q  <= '0;
      vl_q   <= '0;
      base_q <= '0;
    end else begin
      if (accept) begin
        rs1_q <= bus.inst[RS1_LSB +: REG_W];
        rs2_q <= bus.inst[RS2_LSB +: REG_W];
        rd_q  <= bus.inst[RD_LSB +: REG_W];
        alu_q <= bus.inst[ALU_LSB +: ALU_W];
        vl_q  <= vl_eff;
      end
      if (sb_set)         base_q <= '0;
      else if (beat_fire) base_q <= base_next[VLW-1:0];
    end
  end

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < LANES; i++)
      lane_mask[i] = (state_q == ISSUE) && (({1'b0, base_q} + (VLW+1)'(i)) < {1'b0, vl_q});
  end

  assign bus.inst_ready      = inst_ready;
  assign bus.issue_valid     = issue_valid;
  assign bus.issue_rs1       = rs1_q;
  assign bus.issue_rs2       = rs2_q;
  assign bus.issue_rd        = rd_q;
  assign bus.issue_alu_ctrl  = alu_q;
  assign bus.issue_elem_base = base_q;
  assign bus.issue_lane_mask = lane_mask;
  assign bus.issue_last      = (state_q == ISSUE) && last_beat;
  assign bus.busy            = (state_q != IDLE) || sb_any;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Bench for vec_issue_ctrl: directed scenarios plus randomized instructions against a beat/scoreboard model.
module tb_vec_issue_ctrl;

  localparam int MAXVL = 16;
  localparam int LANES = 4;
  localparam int VLW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vec_issue_ctrl_if #(.MAXVL(MAXVL), .LANES(LANES)) bus ();

  vec_issue_ctrl #(.MAXVL(MAXVL), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [3:0]       alu;
    logic [VLW-1:0]   base;
    logic [LANES-1:0] mask;
    logic             last;
  } beat_t;

  int        errors = 0;
  int        checks = 0;
  bit [31:0] sb_model = '0;

  function automatic int veff_of(int vl);
    return (vl > MAXVL) ? MAXVL : vl;
  endfunction

  function automatic int nbeats_of(int vl);
    return (veff_of(vl) + LANES - 1) / LANES;
  endfunction

  function automatic beat_t model_beat(int vl, int b, logic [4:0] rs1, logic [4:0] rs2,
                                       logic [4:0] rd, logic [3:0] alu);
    beat_t m;
    m.rs1  = rs1;
    m.rs2  = rs2;
    m.rd   = rd;
    m.alu  = alu;
    m.base = VLW'(b * LANES);
    for (int i = 0; i < LANES; i++) m.mask[i] = ((b * LANES + i) < veff_of(vl));
    m.last = (b == nbeats_of(vl) - 1);
    return m;
  endfunction

  task automatic accept_inst(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [3:0] alu, input int vl, output bit ok);
    logic [31:0] w;
    w         = $urandom;
    w[19:15]  = rs1;
    w[24:20]  = rs2;
    w[11:7]   = rd;
    w[3:0]    = alu;
    bus.inst       = w;
    bus.vl         = VLW'(vl);
    bus.inst_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.inst_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.inst_valid = 1'b0;
  endtask

  task automatic collect(input int max_cycles, input logic [63:0] ready_pat, output beat_t beats[$],
                         output int first_valid, output int held, output int unstable);
    beat_t cur, prev;
    bit    have_prev, done;
    beats = {};
    first_valid = -1;
    held = 0;
    unstable = 0;
    have_prev = 1'b0;
    done = 1'b0;
    prev = '0;
    for (int k = 0; k < max_cycles; k++) begin
      bus.issue_ready = (k < 64) ? ready_pat[k] : 1'b1;
      cur.rs1  = bus.issue_rs1;
      cur.rs2  = bus.issue_rs2;
      cur.rd   = bus.issue_rd;
      cur.alu  = bus.issue_alu_ctrl;
      cur.base = bus.issue_elem_base;
      cur.mask = bus.issue_lane_mask;
      cur.last = bus.issue_last;
      if (bus.issue_valid) begin
        if (first_valid < 0) first_valid = k;
        if (have_prev && (cur !== prev)) unstable++;
        if (bus.issue_ready) begin
          beats.push_back(cur);
          have_prev = 1'b0;
          if (cur.last) done = 1'b1;
        end else begin
          held++;
          prev = cur;
          have_prev = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (done) break;
    end
    bus.issue_ready = 1'b1;
  endtask

  task automatic do_wb(input logic [4:0] rd);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    if (rd != 5'd0) sb_model[rd] = 1'b0;
  endtask

  task automatic test_reset();
    bus.inst_valid  = 1'b0;
    bus.inst        = '0;
    bus.vl          = '0;
    bus.issue_ready = 1'b1;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.inst_ready !== 1'b1) begin errors++; $display("FAIL reset_inst_ready: got %b expected 1", bus.inst_ready); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0", bus.issue_valid); end
    checks++; if (bus.issue_last !== 1'b0) begin errors++; $display("FAIL reset_issue_last: got %b expected 0", bus.issue_last); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.issue_lane_mask !== '0) begin errors++; $display("FAIL reset_mask: got %b expected 0", bus.issue_lane_mask); end
    checks++;
    if ({bus.issue_rs1, bus.issue_rs2, bus.issue_rd, bus.issue_alu_ctrl, bus.issue_elem_base} !== '0) begin
      errors++;
      $display("FAIL reset_fields: got %h expected 0",
               {bus.issue_rs1, bus.issue_rs2, bus.issue_rd, bus.issue_alu_ctrl, bus.issue_elem_base});
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    beat_t beats[$];
    beat_t exp;
    int    fv, held, unst;
    bit    ok;
    accept_inst(5'd1, 5'd2, 5'd3, 4'h5, 10, ok);
    collect(20, '1, beats, fv, held, unst);
    sb_model[3] = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL basic_accept: got not-ready expected ready"); end
    checks++; if (beats.size() != 3) begin errors++; $display("FAIL basic_nbeats: got %0d expected 3", beats.size()); end
    for (int b = 0; b < beats.size() && b < 3; b++) begin
      exp = model_beat(10, b, 5'd1, 5'd2, 5'd3, 4'h5);
      checks++;
      if (beats[b] !== exp) begin errors++; $display("FAIL basic_beat%0d: got %h expected %h", b, beats[b], exp); end
    end
    checks++; if (fv != 1) begin errors++; $display("FAIL basic_latency: got sample %0d expected 1", fv); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_sb3_held: got busy=%b expected 1", bus.busy); end
    do_wb(5'd3);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_sb3_cleared: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_raw();
    beat_t beats[$];
    beat_t exp;
    int    fv, held, unst;
    bit    ok;
    accept_inst(5'd1, 5'd2, 5'd3, 4'h5, 4, ok);
    collect(20, '1, beats, fv, held, unst);
    sb_model[3] = 1'b1;
    accept_inst(5'd3, 5'd4, 5'd6, 4'h2, 8, ok);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL raw_stall%0d: got issue_valid=%b expected 0", k, bus.issue_valid); end
      @(posedge clk); #1;
    end
    do_wb(5'd3);
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL raw_no_bypass: got issue_valid=%b expected 0", bus.issue_valid); end
    @(posedge clk); #1;
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL raw_release: got issue_valid=%b expected 1", bus.issue_valid); end
    collect(20, '1, beats, fv, held, unst);
    sb_model[6] = 1'b1;
    checks++; if (beats.size() != 2) begin errors++; $display("FAIL raw_nbeats: got %0d expected 2", beats.size()); end
    for (int b = 0; b < beats.size() && b < 2; b++) begin
      exp = model_beat(8, b, 5'd3, 5'd4, 5'd6, 4'h2);
      checks++;
      if (beats[b] !== exp) begin errors++; $display("FAIL raw_beat%0d: got %h expected %h", b, beats[b], exp); end
    end
    do_wb(5'd6);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL raw_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    beat_t beats[$];
    beat_t exp;
    int    fv, held, unst;
    bit    ok;
    accept_inst(5'd9, 5'd10, 5'd11, 4'h3, 12, ok);
    collect(30, ~64'b11100, beats, fv, held, unst);
    sb_model[11] = 1'b1;
    checks++; if (beats.size() != 3) begin errors++; $display("FAIL bp_nbeats: got %0d expected 3", beats.size()); end
    checks++; if (held != 3) begin errors++; $display("FAIL bp_held: got %0d expected 3", held); end
    checks++; if (unst != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", unst); end
    for (int b = 0; b < beats.size() && b < 3; b++) begin
      exp = model_beat(12, b, 5'd9, 5'd10, 5'd11, 4'h3);
      checks++;
      if (beats[b] !== exp) begin errors++; $display("FAIL bp_beat%0d: got %h expected %h", b, beats[b], exp); end
    end
    do_wb(5'd11);
  endtask

  task automatic test_vl_edges();
    beat_t beats[$];
    beat_t exp;
    int    fv, held, unst;
    bit    ok;
    accept_inst(5'd12, 5'd13, 5'd14, 4'h6, 0, ok);
    collect(6, '1, beats, fv, held, unst);
    checks++; if (beats.size() != 0 || fv != -1) begin errors++; $display("FAIL vl0_issue: got %0d beats expected 0", beats.size()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL vl0_sb: got busy=%b expected 0", bus.busy); end
    checks++; if (bus.inst_ready !== 1'b1) begin errors++; $display("FAIL vl0_ready: got %b expected 1", bus.inst_ready); end
    accept_inst(5'd1, 5'd1, 5'd15, 4'h7, 31, ok);
    collect(20, '1, beats, fv, held, unst);
    sb_model[15] = 1'b1;
    checks++; if (beats.size() != 4) begin errors++; $display("FAIL vl31_nbeats: got %0d expected 4", beats.size()); end
    for (int b = 0; b < beats.size() && b < 4; b++) begin
      exp = model_beat(31, b, 5'd1, 5'd1, 5'd15, 4'h7);
      checks++;
      if (beats[b] !== exp) begin errors++; $display("FAIL vl31_beat%0d: got %h expected %h", b, beats[b], exp); end
    end
    do_wb(5'd15);
  endtask

  task automatic test_rd_zero();
    beat_t beats[$];
    beat_t exp;
    int    fv, held, unst;
    bit    ok;
    accept_inst(5'd5, 5'd6, 5'd0, 4'h8, 7, ok);
    collect(20, '1, beats, fv, held, unst);
    checks++; if (beats.size() != 2) begin errors++; $display("FAIL rd0_nbeats: got %0d expected 2", beats.size()); end
    for (int b = 0; b < beats.size() && b < 2; b++) begin
      exp = model_beat(7, b, 5'd5, 5'd6, 5'd0, 4'h8);
      checks++;
      if (beats[b] !== exp) begin errors++; $display("FAIL rd0_beat%0d: got %h expected %h", b, beats[b], exp); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rd0_sb: got busy=%b expected 0", bus.busy); end
    accept_inst(5'd0, 5'd0, 5'd7, 4'h9, 5, ok);
    collect(20, '1, beats, fv, held, unst);
    sb_model[7] = 1'b1;
    checks++; if (fv != 1) begin errors++; $display("FAIL rd0_nostall: got sample %0d expected 1", fv); end
    checks++; if (beats.size() != 2) begin errors++; $display("FAIL rd0_follow_nbeats: got %0d expected 2", beats.size()); end
    do_wb(5'd7);
  endtask

  task automatic test_reset_mid();
    beat_t beats[$];
    int    fv, held, unst;
    bit    ok, seen;
    accept_inst(5'd2, 5'd3, 5'd9, 4'h4, 16, ok);
    bus.issue_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.issue_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++;
    if (!seen || bus.issue_elem_base !== VLW'(4)) begin
      errors++;
      $display("FAIL rstmid_beat1: got base=%0d expected 4", bus.issue_elem_base);
    end
    rst = 1'b0;
    #1;
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.issue_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_sb: got busy=%b expected 0", bus.busy); end
    checks++; if (bus.inst_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", bus.inst_ready); end
    checks++; if (bus.issue_lane_mask !== '0) begin errors++; $display("FAIL rstmid_mask: got %b expected 0", bus.issue_lane_mask); end
    #1;
    rst = 1'b1;
    sb_model = '0;
    @(posedge clk); #1;
    accept_inst(5'd9, 5'd2, 5'd9, 4'h1, 4, ok);
    collect(20, '1, beats, fv, held, unst);
    sb_model[9] = 1'b1;
    checks++; if (fv != 1 || beats.size() != 1) begin errors++; $display("FAIL rstmid_next: got first=%0d beats=%0d expected 1/1", fv, beats.size()); end
    do_wb(5'd9);
  endtask

  task automatic test_random();
    beat_t       beats[$];
    beat_t       exp;
    int          fv, held, unst, vl, nb, exp_fv;
    bit          ok, exp_haz;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [63:0] pat;
    bit [31:0]   conflict;
    for (int n = 0; n < 40; n++) begin
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      alu = 4'($urandom);
      vl  = $urandom_range(0, 31);
      pat = {32'($urandom), 32'($urandom)};
      nb  = nbeats_of(vl);
      conflict = sb_model & ((32'd1 << rs1) | (32'd1 << rs2) | (32'd1 << rd));
      exp_haz  = (veff_of(vl) != 0) && (conflict != 0);
      accept_inst(rs1, rs2, rd, alu, vl, ok);
      if (exp_haz) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_stall: got issue_valid=%b expected 0", n, bus.issue_valid); end
          @(posedge clk); #1;
        end
        for (int r = 1; r < 32; r++)
          if (conflict[r]) do_wb(5'(r));
      end
      collect(100, pat, beats, fv, held, unst);
      if (veff_of(vl) != 0 && rd != 5'd0) sb_model[rd] = 1'b1;
      exp_fv = (nb > 0) ? 1 : -1;
      checks++; if (fv != exp_fv) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, fv, exp_fv); end
      checks++; if (beats.size() != nb) begin errors++; $display("FAIL rnd%0d_nbeats: got %0d expected %0d", n, beats.size(), nb); end
      checks++; if (unst != 0) begin errors++; $display("FAIL rnd%0d_stable: got %0d changes expected 0", n, unst); end
      for (int b = 0; b < beats.size() && b < nb; b++) begin
        exp = model_beat(vl, b, rs1, rs2, rd, alu);
        checks++;
        if (beats[b] !== exp) begin errors++; $display("FAIL rnd%0d_beat%0d: got %h expected %h", n, b, beats[b], exp); end
      end
      if (rd != 5'd0 && $urandom_range(0, 1) == 1) do_wb(rd);
      checks++;
      if (bus.busy !== (sb_model != 0)) begin errors++; $display("FAIL rnd%0d_busy: got %b expected %b", n, bus.busy, (sb_model != 0)); end
    end
    for (int r = 1; r < 32; r++)
      if (sb_model[r]) do_wb(5'(r));
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rnd_drain_busy: got %b expected 0", bus.busy); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_backpressure();
    test_vl_edges();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_issue_ctrl.md
# vec_issue_ctrl

Issue controller between instruction fetch and the vector ALU datapath. It accepts one 32-bit instruction at a time over a valid/ready handshake and extracts rs1/rs2/rd/alu_control from the instruction word. It holds the instruction until a register scoreboard shows no RAW/WAW hazard, then sequences it as ceil(vl/LANES) lane-parallel beats to the ALU. It frees destination registers on ALU writeback.

## Interface
- MAXVL, 16: maximum vector length in elements; power of two, ≥ LANES.
- LANES, 4: elements processed per ALU beat; power of two.
- VLW, $clog2(MAXVL+1): width of vl.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; one clock domain.
- inst_valid  in  1  instruction word valid.
- inst  in  32  instruction word.
- inst_ready  out  1  controller can accept an instruction.
- vl  in  VLW  current vector length; sampled on accept.
- issue_valid  out  1  beat presented to ALU.
- issue_ready  in  1  ALU accepts beat.
- issue_rs1 / issue_rs2 / issue_rd  out  5 each  register indices.
- issue_alu_ctrl  out  4  ALU opcode.
- issue_elem_base  out  VLW  index of element in lane 0 of this beat.
- issue_lane_mask  out  LANES  active lanes this beat.
- issue_last  out  1  final beat of instruction.
- wb_valid  in  1  ALU completed the final beat of an instruction.
- wb_rd  in  5  destination register being released.
- busy  out  1  state ≠ IDLE, or any scoreboard bit set.

## Operation
- Field extraction on accept: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7], alu=inst[3:0].
- vl is clamped: vl_eff = min(vl, MAXVL).
- FSM states: IDLE, HAZARD, ISSUE.
- IDLE: inst_ready=1. On inst_valid&inst_ready, latch fields and vl_eff.
  - vl_eff==0: instruction is dropped (no issue, no scoreboard change); stay IDLE.
  - vl_eff≠0: go to HAZARD.
- HAZARD: stall while sb[rs1]|sb[rs2]|sb[rd]. When clear, set sb[rd] (register 0 is never marked), clear beat counter, and go to ISSUE.
- ISSUE:
  - issue_valid=1; outputs are stable while issue_valid&!issue_ready.
  - beat b: elem_base=b*LANES; lane i active iff b*LANES+i < vl_eff.
  - issue_last = (b == ceil(vl_eff/LANES)-1).
  - On handshake: b++. On the handshake of the last beat, go to IDLE.
- Scoreboard: 32 flops. wb_valid clears sb[wb_rd]; wb_valid with wb_rd=0 is a no-op.
- Simultaneous set (HAZARD exit) and clear of the same index cannot occur: rd must be non-busy to set. Clear of a different index takes effect normally.
- The hazard check uses registered sb with no same-cycle writeback bypass: a clear in cycle N allows issue entry in cycle N+1.
- Back-to-back independent instructions are allowed; only registers are tracked.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE and scoreboard cleared.
  - issue_valid, issue_last, busy, issue_* fields, and issue_lane_mask are all 0.
  - inst_ready=1 (combinational from state).
- inst_ready and issue_valid are decoded from the state register; there are no combinational paths from inputs to outputs.
- Latency from accept to first issue_valid, no hazard: accept at edge N → HAZARD at N+1 → ISSUE at N+2, so issue_valid is high after edge N+2.
- Throughput: one beat per cycle with issue_ready held high. An instruction occupies ceil(vl_eff/LANES)+2 cycles. The next accept happens in the cycle after the last beat's handshake.
- Reset asserted mid-operation aborts the instruction: no further beats, and all pending scoreboard bits are lost.

## Structure
- A shared package `vec_pkg` holds:
  - the state enum (IDLE/HAZARD/ISSUE);
  - field-position localparams (RS1_LSB=15, RS2_LSB=20, RD_LSB=7, ALU_LSB=0);
  - the REG_W=5 and ALU_W=4 constants.
- Sub-module `vec_scoreboard`:
  - 32-bit busy vector with set port (index, en) and clear port (index, en);
  - three combinational read ports;
  - register 0 is hardwired to 0.
- Beat counter, lane-mask generation, and the FSM live in vec_issue_ctrl.

## Test plan
- Reset release, then inst with rs1=1, rs2=2, rd=3, alu=4'h5, vl=10, LANES=4, issue_ready=1 → 3 beats with elem_base 0/4/8, masks 1111/1111/0011, issue_last on the 3rd beat, sb[3]=1 until wb_valid with wb_rd=3.
- RAW: rd=3 pending; next inst reads rs1=3 → stays in HAZARD with issue_valid=0. wb_rd=3 at cycle N → first beat issue_valid high after edge N+2.
- Backpressure: issue_ready low for 3 cycles mid-instruction → fields and mask held stable, no beat skipped or duplicated.
- vl=0 → accepted, no issue_valid, sb unchanged. vl=31 with MAXVL=16 → clamped to 16, 4 full beats.
- rd=0 → issues normally, sb[0] stays 0, and a following inst with rs1=0 issues without stall.
- rst pulsed low during the 2nd beat → issue_valid drops immediately, sb all 0, inst_ready=1, and the next instruction is accepted normally.
